// File: rtl/sdram_cmd_responder.sv
// Device-side responder/checker for the SDRAM command bus: decodes commands, tracks
// bank and self-refresh state, enforces tRP/tRFC/tXSR and flags protocol violations.
module sdram_cmd_responder #(
  parameter int T_RP  = 2,
  parameter int T_RFC = 7,
  parameter int T_XSR = 7
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        sdram_cke,
  input  logic [3:0]  sdram_cmd,
  input  logic [1:0]  sdram_ba,
  input  logic [11:0] sdram_addr,
  output logic [3:0]  bank_open,
  output logic        in_self_ref,
  output logic        busy,
  output logic        sr_exit_ready,
  output logic [12:0] ref_cnt,
  output logic        err_timing,
  output logic        err_illegal,
  output logic        err_sticky
);

  localparam int T_MAX = (T_RP > T_RFC) ? ((T_RP > T_XSR) ? T_RP : T_XSR)
                                        : ((T_RFC > T_XSR) ? T_RFC : T_XSR);
  localparam int CW = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] RP_LOAD  = CW'(T_RP - 1);
  localparam logic [CW-1:0] RFC_LOAD = CW'(T_RFC - 1);
  localparam logic [CW-1:0] XSR_LOAD = CW'(T_XSR - 1);

  localparam logic [3:0] CMD_NOP        = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
  localparam logic [3:0] CMD_READ       = 4'b0101;
  localparam logic [3:0] CMD_WRITE      = 4'b0100;
  localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REF   = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE  = 4'b0000;
  localparam logic [3:0] CMD_BURST_STOP = 4'b0110;

  typedef enum logic [1:0] {
    ST_NORMAL,
    ST_SELF_REF,
    ST_EXIT
  } state_t;

  state_t        state, state_n;
  logic          cke_q;
  logic [CW-1:0] rp_cnt, rfc_cnt, xsr_cnt;
  logic [CW-1:0] rp_n, rfc_n, xsr_n;
  logic [CW-1:0] rp_dec, rfc_dec, xsr_dec;
  logic [3:0]    bank_n;
  logic [12:0]   ref_n;
  logic          in_sr_n, exit_rdy_n, err_t_n, err_i_n;
  logic          is_nop, any_open, cke_rise, apply_cmd;

  // Only addr[10] matters to this device model.
  logic unused_addr;
  assign unused_addr = ^{sdram_addr[11], sdram_addr[9:0]};

  assign busy = (rp_cnt != '0) || (rfc_cnt != '0) || (xsr_cnt != '0);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= ST_NORMAL;
      cke_q         <= 1'b1;
      rp_cnt        <= '0;
      rfc_cnt       <= '0;
      xsr_cnt       <= '0;
      bank_open     <= '0;
      ref_cnt       <= '0;
      in_self_ref   <= 1'b0;
      sr_exit_ready <= 1'b0;
      err_timing    <= 1'b0;
      err_illegal   <= 1'b0;
      err_sticky    <= 1'b0;
    end else begin
      state         <= state_n;
      cke_q         <= sdram_cke;
      rp_cnt        <= rp_n;
      rfc_cnt       <= rfc_n;
      xsr_cnt       <= xsr_n;
      bank_open     <= bank_n;
      ref_cnt       <= ref_n;
      in_self_ref   <= in_sr_n;
      sr_exit_ready <= exit_rdy_n;
      err_timing    <= err_t_n;
      err_illegal   <= err_i_n;
      err_sticky    <= err_sticky | err_t_n | err_i_n;
    end
  end

  always_comb begin
    is_nop   = sdram_cmd[3] || (sdram_cmd == CMD_NOP);
    any_open = |bank_open;
    cke_rise = sdram_cke && !cke_q;
    rp_dec   = (rp_cnt  != '0) ? rp_cnt  - CW'(1) : '0;
    rfc_dec  = (rfc_cnt != '0) ? rfc_cnt - CW'(1) : '0;
    xsr_dec  = (xsr_cnt != '0) ? xsr_cnt - CW'(1) : '0;

    state_n    = state;
    bank_n     = bank_open;
    ref_n      = ref_cnt;
    in_sr_n    = in_self_ref;
    rp_n       = rp_dec;
    rfc_n      = rfc_dec;
    xsr_n      = xsr_dec;
    exit_rdy_n = 1'b0;
    err_t_n    = !is_nop && busy;
    err_i_n    = 1'b0;
    apply_cmd  = 1'b0;

    // The CKE-rise cycle already behaves as a CKE-high cycle, so its command is decoded normally.
    case (state)
      ST_SELF_REF: begin
        if (cke_rise) begin
          state_n   = ST_EXIT;
          in_sr_n   = 1'b0;
          xsr_n     = (xsr_dec > XSR_LOAD) ? xsr_dec : XSR_LOAD;
          apply_cmd = 1'b1;
        end else if (!is_nop) begin
          err_i_n = 1'b1;
        end
      end
      default: begin
        if (state == ST_EXIT && xsr_cnt == CW'(1)) begin
          exit_rdy_n = 1'b1;
          state_n    = ST_NORMAL;
        end
        apply_cmd = 1'b1;
      end
    endcase

    if (apply_cmd) begin
      if (!sdram_cke) begin
        if (sdram_cmd == CMD_AUTO_REF && cke_q) begin
          if (any_open) begin
            err_i_n = 1'b1;
          end else begin
            state_n = ST_SELF_REF;
            in_sr_n = 1'b1;
            ref_n   = '0;
          end
        end else begin
          err_i_n = 1'b1;
        end
      end else begin
        case (sdram_cmd)
          CMD_ACTIVE: begin
            if (bank_open[sdram_ba]) err_i_n = 1'b1;
            bank_n[sdram_ba] = 1'b1;
          end
          CMD_READ, CMD_WRITE: begin
            if (!bank_open[sdram_ba]) err_i_n = 1'b1;
          end
          CMD_PRECHARGE: begin
            if (sdram_addr[10]) bank_n = '0;
            else                bank_n[sdram_ba] = 1'b0;
            rp_n = (rp_dec > RP_LOAD) ? rp_dec : RP_LOAD;
          end
          CMD_AUTO_REF: begin
            if (any_open) begin
              err_i_n = 1'b1;
            end else begin
              rfc_n = (rfc_dec > RFC_LOAD) ? rfc_dec : RFC_LOAD;
              if (ref_cnt != 13'h1fff) ref_n = ref_cnt + 13'd1;
            end
          end
          CMD_LOAD_MODE: begin
            if (any_open) err_i_n = 1'b1;
          end
          CMD_BURST_STOP: ;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Directed self-checking bench for sdram_cmd_responder; expected values are hand-derived
// from the command timeline (one command per cycle, outputs checked one cycle later).
module tb_sdram_cmd_responder;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] ACT  = 4'b0011;
  localparam logic [3:0] RD   = 4'b0101;
  localparam logic [3:0] WR   = 4'b0100;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] LMR  = 4'b0000;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        sdram_cke = 1'b1;
  logic [3:0]  sdram_cmd = NOP;
  logic [1:0]  sdram_ba = '0;
  logic [11:0] sdram_addr = '0;
  logic [3:0]  bank_open;
  logic        in_self_ref, busy, sr_exit_ready, err_timing, err_illegal, err_sticky;
  logic [12:0] ref_cnt;

  int total = 0;
  int bad = 0;
  logic errSeen;

  sdram_cmd_responder dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .sdram_cke(sdram_cke),
    .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .bank_open(bank_open), .in_self_ref(in_self_ref), .busy(busy),
    .sr_exit_ready(sr_exit_ready), .ref_cnt(ref_cnt), .err_timing(err_timing),
    .err_illegal(err_illegal), .err_sticky(err_sticky)
  );

  always #5 sys_clk = ~sys_clk;

  // Drives one command for one cycle; returns 1 ns after the edge that sampled it.
  task automatic applyStimulus(input logic cke, input logic [3:0] cmd,
                               input logic [1:0] ba, input logic [11:0] addr);
    sdram_cke  = cke;
    sdram_cmd  = cmd;
    sdram_ba   = ba;
    sdram_addr = addr;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nops(input int n, input logic cke);
    for (int i = 0; i < n; i++) applyStimulus(cke, NOP, 2'd0, 12'h000);
  endtask

  initial begin
    nops(2, 1'b1);
    sys_rst = 1'b0;
    checkOutput("rst_bank_open", 32'(bank_open), 32'h0);
    checkOutput("rst_in_self_ref", 32'(in_self_ref), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_ref_cnt", 32'(ref_cnt), 32'h0);
    checkOutput("rst_err_sticky", 32'(err_sticky), 32'h0);
    checkOutput("rst_exit_ready", 32'(sr_exit_ready), 32'h0);

    // PRECHARGE all, NOP, AUTO_REF at exactly tRP: legal, busy for tRFC.
    applyStimulus(1'b1, PRE, 2'd0, 12'hfff);
    checkOutput("pre_busy", 32'(busy), 32'h1);
    applyStimulus(1'b1, NOP, 2'd0, 12'h000);
    checkOutput("pre_busy_done", 32'(busy), 32'h0);
    applyStimulus(1'b1, AREF, 2'd0, 12'h000);
    checkOutput("aref_err_timing", 32'(err_timing), 32'h0);
    checkOutput("aref_err_illegal", 32'(err_illegal), 32'h0);
    checkOutput("aref_ref_cnt", 32'(ref_cnt), 32'h1);
    nops(5, 1'b1);
    checkOutput("rfc_busy_last", 32'(busy), 32'h1);
    applyStimulus(1'b1, NOP, 2'd0, 12'h000);
    checkOutput("rfc_busy_clear", 32'(busy), 32'h0);
    checkOutput("no_err_yet", 32'(err_sticky), 32'h0);

    // ACTIVE one cycle after PRECHARGE: timing error, bank still opened.
    applyStimulus(1'b1, PRE, 2'd0, 12'h000);
    applyStimulus(1'b1, ACT, 2'd1, 12'h000);
    checkOutput("trp_err_timing", 32'(err_timing), 32'h1);
    checkOutput("trp_err_illegal", 32'(err_illegal), 32'h0);
    checkOutput("trp_err_sticky", 32'(err_sticky), 32'h1);
    checkOutput("trp_bank_open", 32'(bank_open), 32'h2);
    applyStimulus(1'b1, NOP, 2'd0, 12'h000);
    checkOutput("trp_pulse_end", 32'(err_timing), 32'h0);
    checkOutput("trp_sticky_hold", 32'(err_sticky), 32'h1);

    // Self-refresh entry, illegal command inside, exit with AUTO_REF on the CKE rise.
    applyStimulus(1'b1, PRE, 2'd0, 12'hfff);
    nops(2, 1'b1);
    applyStimulus(1'b0, AREF, 2'd0, 12'h000);
    checkOutput("sr_in", 32'(in_self_ref), 32'h1);
    checkOutput("sr_ref_clr", 32'(ref_cnt), 32'h0);
    checkOutput("sr_entry_illegal", 32'(err_illegal), 32'h0);
    nops(3, 1'b0);
    checkOutput("sr_hold", 32'(in_self_ref), 32'h1);
    checkOutput("sr_nop_legal", 32'(err_illegal), 32'h0);
    applyStimulus(1'b0, ACT, 2'd0, 12'h000);
    checkOutput("sr_act_illegal", 32'(err_illegal), 32'h1);
    checkOutput("sr_act_no_timing", 32'(err_timing), 32'h0);
    checkOutput("sr_act_no_bank", 32'(bank_open), 32'h0);
    applyStimulus(1'b0, NOP, 2'd0, 12'h000);
    applyStimulus(1'b1, AREF, 2'd0, 12'h000);
    checkOutput("exit_in_sr", 32'(in_self_ref), 32'h0);
    checkOutput("exit_aref_illegal", 32'(err_illegal), 32'h0);
    checkOutput("exit_aref_timing", 32'(err_timing), 32'h0);
    checkOutput("exit_aref_cnt", 32'(ref_cnt), 32'h1);
    applyStimulus(1'b1, AREF, 2'd0, 12'h000);
    checkOutput("exit_aref2_timing", 32'(err_timing), 32'h1);
    checkOutput("exit_aref2_cnt", 32'(ref_cnt), 32'h2);
    nops(4, 1'b1);
    checkOutput("xsr_not_yet", 32'(sr_exit_ready), 32'h0);
    applyStimulus(1'b1, NOP, 2'd0, 12'h000);
    checkOutput("xsr_pulse", 32'(sr_exit_ready), 32'h1);
    checkOutput("xsr_rfc_busy", 32'(busy), 32'h1);
    applyStimulus(1'b1, NOP, 2'd0, 12'h000);
    checkOutput("xsr_pulse_end", 32'(sr_exit_ready), 32'h0);
    checkOutput("xsr_idle", 32'(busy), 32'h0);

    // Fresh SR cycle, then 4096 refreshes spaced 9 cycles.
    applyStimulus(1'b0, AREF, 2'd0, 12'h000);
    applyStimulus(1'b0, NOP, 2'd0, 12'h000);
    applyStimulus(1'b1, NOP, 2'd0, 12'h000);
    nops(6, 1'b1);
    errSeen = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      applyStimulus(1'b1, AREF, 2'd0, 12'h000);
      errSeen = errSeen | err_timing | err_illegal;
      for (int j = 0; j < 8; j++) begin
        applyStimulus(1'b1, NOP, 2'd0, 12'h000);
        errSeen = errSeen | err_timing | err_illegal;
      end
    end
    checkOutput("loop_no_err", 32'(errSeen), 32'h0);
    checkOutput("loop_ref_cnt", 32'(ref_cnt), 32'd4096);
    applyStimulus(1'b1, AREF, 2'd0, 12'h000);
    nops(6, 1'b1);
    applyStimulus(1'b1, AREF, 2'd0, 12'h000);
    checkOutput("trfc_edge_timing", 32'(err_timing), 32'h0);
    checkOutput("trfc_edge_cnt", 32'(ref_cnt), 32'd4098);
    nops(7, 1'b1);

    // Bank rule violations.
    applyStimulus(1'b1, ACT, 2'd2, 12'h000);
    checkOutput("act2_bank", 32'(bank_open), 32'h4);
    checkOutput("act2_legal", 32'(err_illegal), 32'h0);
    applyStimulus(1'b1, AREF, 2'd0, 12'h000);
    checkOutput("aref_open_illegal", 32'(err_illegal), 32'h1);
    checkOutput("aref_open_cnt", 32'(ref_cnt), 32'd4098);
    applyStimulus(1'b1, RD, 2'd1, 12'h000);
    checkOutput("rd_closed_illegal", 32'(err_illegal), 32'h1);
    applyStimulus(1'b1, WR, 2'd2, 12'h000);
    checkOutput("wr_open_legal", 32'(err_illegal), 32'h0);
    applyStimulus(1'b1, ACT, 2'd2, 12'h000);
    checkOutput("act_open_illegal", 32'(err_illegal), 32'h1);
    applyStimulus(1'b1, LMR, 2'd0, 12'h000);
    checkOutput("lmr_open_illegal", 32'(err_illegal), 32'h1);
    applyStimulus(1'b1, PRE, 2'd2, 12'h000);
    checkOutput("pre_bank2", 32'(bank_open), 32'h0);
    checkOutput("pre_bank2_legal", 32'(err_illegal), 32'h0);
    applyStimulus(1'b1, NOP, 2'd0, 12'h000);
    applyStimulus(1'b0, NOP, 2'd0, 12'h000);
    checkOutput("cke_low_normal", 32'(err_illegal), 32'h1);
    checkOutput("cke_low_no_sr", 32'(in_self_ref), 32'h0);
    applyStimulus(1'b1, NOP, 2'd0, 12'h000);

    // Reset while in self-refresh.
    applyStimulus(1'b0, AREF, 2'd0, 12'h000);
    checkOutput("sr_before_rst", 32'(in_self_ref), 32'h1);
    sys_rst = 1'b1;
    applyStimulus(1'b0, NOP, 2'd0, 12'h000);
    checkOutput("rst_sr_in", 32'(in_self_ref), 32'h0);
    checkOutput("rst_sr_sticky", 32'(err_sticky), 32'h0);
    checkOutput("rst_sr_ref", 32'(ref_cnt), 32'h0);
    checkOutput("rst_sr_bank", 32'(bank_open), 32'h0);
    checkOutput("rst_sr_busy", 32'(busy), 32'h0);
    sys_rst = 1'b0;
    applyStimulus(1'b1, NOP, 2'd0, 12'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
